// File: rtl/trigger_ctrl.sv
// Oscilloscope trigger/acquisition controller: fills a circular frame RAM with
//   PRE_TRIG pre-trigger samples, waits for a level/slope crossing, fills the
//   remainder of the frame, then hands the frame to the display read-out.
// Ports: sys_clk/sys_rst (sync, active-high); sample_en/adc_data sample strobe
//   and data; trig_level/trig_slope trigger setup; single_mode/arm acquisition
//   control; rd_en display read strobe; wr_addr/wr_en RAM write side; rd_addr
//   RAM read side; trig_addr trigger sample address; frame_ready; state code.
// Optional macro TRIG_AUTO_TIMEOUT_EN: forces a trigger after TIMEOUT samples
//   spent waiting; when undefined the wait is unbounded and no counter exists.

module trigger_ctrl #(
   parameter int DEPTH    = 400,
   parameter int PRE_TRIG = 100,
   parameter int TIMEOUT  = 4000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       sample_en,
   input  logic [7:0] adc_data,
   input  logic [7:0] trig_level,
   input  logic       trig_slope,
   input  logic       single_mode,
   input  logic       arm,
   input  logic       rd_en,
   output logic [8:0] wr_addr,
   output logic       wr_en,
   output logic [8:0] rd_addr,
   output logic [8:0] trig_addr,
   output logic       frame_ready,
   output logic [2:0] state
);

   // Reject configurations the 9-bit address ports or the frame split cannot hold.
   if (DEPTH > 512 || DEPTH < 3 || PRE_TRIG < 1 || PRE_TRIG > DEPTH - 2 || TIMEOUT < 1) begin : g_bad_param
      $error("trigger_ctrl: illegal DEPTH/PRE_TRIG/TIMEOUT");
   end

   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_TRIG - 1);
   // The trigger sample itself is the first of the post-trigger part.
   localparam logic [CW-1:0] POST_LAST = CW'(DEPTH - PRE_TRIG - 2);
   localparam logic [CW-1:0] RD_LAST   = CW'(DEPTH - 1);
   localparam logic [8:0]    ADDR_LAST = 9'(DEPTH - 1);
   localparam logic [9:0]    OFFS10    = 10'(DEPTH - PRE_TRIG);
   localparam logic [9:0]    DEPTH10   = 10'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_WAIT = 3'd2,
      ST_POST = 3'd3,
      ST_DISP = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [8:0]      wr_addr_q, rd_addr_q, trig_addr_q;
   logic [CW-1:0]   pre_cnt_q, post_cnt_q, rd_cnt_q;
   logic [7:0]      prev_q;
   logic            mode_q;

   logic            acq, smp, rd_go;
   logic            edge_hit, trig_hit;
   logic            pre_done, post_done, rd_done;
   logic            enter_pre, load_rd;
   logic [8:0]      wr_addr_nxt, rd_addr_nxt, rd_start;
   logic [9:0]      start_sum;

   assign acq       = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
   assign smp       = acq && sample_en;
   assign rd_go     = (state_q == ST_DISP) && rd_en;

   assign edge_hit  = trig_slope ? ((prev_q < trig_level) && (adc_data >= trig_level))
                                 : ((prev_q > trig_level) && (adc_data <= trig_level));

`ifdef TRIG_AUTO_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_cnt_q;

   // Counts samples already seen in WAIT; the current sample is the one that
   // brings the count to TIMEOUT when TIMEOUT-1 have gone before it.
   assign trig_hit = edge_hit || (to_cnt_q == TW'(TIMEOUT - 1));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         to_cnt_q <= '0;
      end else if (enter_pre) begin
         to_cnt_q <= '0;
      end else if (smp && (state_q == ST_WAIT)) begin
         to_cnt_q <= to_cnt_q + TW'(1);
      end
   end
`else
   assign trig_hit = edge_hit;
`endif

   assign pre_done    = (pre_cnt_q == PRE_LAST);
   assign post_done   = (post_cnt_q == POST_LAST);
   assign rd_done     = (rd_cnt_q == RD_LAST);

   assign wr_addr_nxt = (wr_addr_q == ADDR_LAST) ? 9'd0 : wr_addr_q + 9'd1;
   assign rd_addr_nxt = (rd_addr_q == ADDR_LAST) ? 9'd0 : rd_addr_q + 9'd1;

   // Oldest sample of the frame sits DEPTH-PRE_TRIG slots after the trigger.
   assign start_sum   = {1'b0, trig_addr_q} + OFFS10;
   assign rd_start    = (start_sum >= DEPTH10) ? 9'(start_sum - DEPTH10) : start_sum[8:0];

   assign enter_pre   = (state_d == ST_PRE) && (state_q != ST_PRE);
   assign load_rd     = (state_q == ST_POST) && (state_d == ST_DISP);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (arm) state_d = ST_PRE;
         ST_PRE:  if (sample_en && pre_done) state_d = ST_WAIT;
         ST_WAIT: if (sample_en && trig_hit) state_d = ST_POST;
         ST_POST: if (sample_en && post_done) state_d = ST_DISP;
         ST_DISP: begin
            // mode_q is the mode captured at the start of this frame, so a
            // toggle of single_mode mid-frame does not change this decision.
            if (arm) begin
               state_d = ST_PRE;
            end else if (rd_en && rd_done && !mode_q) begin
               state_d = ST_PRE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      wr_en       = 1'b0;
      frame_ready = 1'b0;
      if (!sys_rst) begin
         wr_en       = smp;
         frame_ready = (state_q == ST_DISP);
      end
   end

   // ---------------- datapath ----------------
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         trig_addr_q <= '0;
         pre_cnt_q   <= '0;
         post_cnt_q  <= '0;
         rd_cnt_q    <= '0;
         prev_q      <= '0;
         mode_q      <= 1'b0;
      end else begin
         if (enter_pre) begin
            wr_addr_q  <= '0;
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
            mode_q     <= single_mode;
         end else if (smp) begin
            wr_addr_q <= wr_addr_nxt;
            prev_q    <= adc_data;
            if (state_q == ST_PRE)  pre_cnt_q  <= pre_cnt_q + CW'(1);
            if (state_q == ST_POST) post_cnt_q <= post_cnt_q + CW'(1);
         end

         if (smp && (state_q == ST_WAIT) && trig_hit) begin
            trig_addr_q <= wr_addr_q;
         end

         if (load_rd) begin
            rd_addr_q <= rd_start;
            rd_cnt_q  <= '0;
         end else if (rd_go) begin
            rd_addr_q <= rd_addr_nxt;
            rd_cnt_q  <= rd_done ? '0 : rd_cnt_q + CW'(1);
         end
      end
   end

   assign wr_addr   = wr_addr_q;
   assign rd_addr   = rd_addr_q;
   assign trig_addr = trig_addr_q;
   assign state     = state_q;

endmodule

// File: tb/tb_trigger_ctrl.sv
// Self-checking bench for trigger_ctrl with default parameters
// (DEPTH=400, PRE_TRIG=100, TIMEOUT=4000).

module tb_trigger_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       sample_en = 1'b0;
   logic [7:0] adc_data = 8'd0;
   logic [7:0] trig_level = 8'd128;
   logic       trig_slope = 1'b1;
   logic       single_mode = 1'b0;
   logic       arm = 1'b0;
   logic       rd_en = 1'b0;
   logic [8:0] wr_addr;
   logic       wr_en;
   logic [8:0] rd_addr;
   logic [8:0] trig_addr;
   logic       frame_ready;
   logic [2:0] state;

   int errs   = 0;
   int checks = 0;

   trigger_ctrl dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .sample_en   (sample_en),
      .adc_data    (adc_data),
      .trig_level  (trig_level),
      .trig_slope  (trig_slope),
      .single_mode (single_mode),
      .arm         (arm),
      .rd_en       (rd_en),
      .wr_addr     (wr_addr),
      .wr_en       (wr_en),
      .rd_addr     (rd_addr),
      .trig_addr   (trig_addr),
      .frame_ready (frame_ready),
      .state       (state)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic       slope;
      logic [7:0] level;
      logic [7:0] prev;
      logic [7:0] cur;
      logic [2:0] exp_state;
      logic [8:0] exp_trig;
   } vec_t;

   vec_t vt[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic sample(input logic [7:0] d);
      adc_data  = d;
      sample_en = 1'b1;
      tick();
      sample_en = 1'b0;
   endtask

   task automatic read_one();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      tick();
      tick();
      sys_rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            slope level prev cur  state trig
      vt[0] = '{1'b1, 8'd128, 8'd100, 8'd130, 3'd3, 9'd100}; // rising cross
      vt[1] = '{1'b1, 8'd128, 8'd127, 8'd128, 3'd3, 9'd100}; // rising, cur == level
      vt[2] = '{1'b1, 8'd128, 8'd128, 8'd200, 3'd2, 9'd0};   // prev already at level
      vt[3] = '{1'b1, 8'd128, 8'd100, 8'd127, 3'd2, 9'd0};   // stays below
      vt[4] = '{1'b0, 8'd128, 8'd200, 8'd100, 3'd3, 9'd100}; // falling cross
      vt[5] = '{1'b0, 8'd128, 8'd129, 8'd128, 3'd3, 9'd100}; // falling, cur == level
      vt[6] = '{1'b0, 8'd128, 8'd128, 8'd0,   3'd2, 9'd0};   // prev at level, not above
      vt[7] = '{1'b0, 8'd128, 8'd200, 8'd129, 3'd2, 9'd0};   // stays above
      vt[8] = '{1'b1, 8'd0,   8'd0,   8'd0,   3'd2, 9'd0};   // level 0 can never rise
      vt[9] = '{1'b0, 8'd255, 8'd255, 8'd10,  3'd2, 9'd0};   // level 255 can never fall

      // ---------- reset state ----------
      sample_en = 1'b1;
      rd_en     = 1'b1;
      tick();
      check("rst_wr_en", 32'(wr_en), 32'd0);
      do_reset();
      sample_en = 1'b1;
      rd_en     = 1'b1;
      #1;
      check("idle_state", 32'(state), 32'd0);
      check("idle_wr_en", 32'(wr_en), 32'd0);
      tick();
      check("idle_wr_addr", 32'(wr_addr), 32'd0);
      check("idle_rd_addr", 32'(rd_addr), 32'd0);
      check("idle_trig_addr", 32'(trig_addr), 32'd0);
      check("idle_frame_ready", 32'(frame_ready), 32'd0);
      sample_en = 1'b0;
      rd_en     = 1'b0;

      // ---------- trigger detection table ----------
      for (int i = 0; i < 10; i++) begin
         do_reset();
         trig_slope = vt[i].slope;
         trig_level = vt[i].level;
         pulse_arm();
         repeat (100) sample(vt[i].prev);
         sample(vt[i].cur);
         check($sformatf("vec%0d_state", i), 32'(state), 32'(vt[i].exp_state));
         check($sformatf("vec%0d_trig_addr", i), 32'(trig_addr), 32'(vt[i].exp_trig));
      end

      // ---------- pre-trigger fill, rising trigger at 150, repetitive read-out ----------
      do_reset();
      trig_slope  = 1'b1;
      trig_level  = 8'd128;
      single_mode = 1'b0;
      pulse_arm();
      check("arm_state", 32'(state), 32'd1);
      adc_data  = 8'd50;
      sample_en = 1'b1;
      #1;
      check("pre_wr_en_hi", 32'(wr_en), 32'd1);
      tick();
      sample_en = 1'b0;
      #1;
      check("pre_wr_en_lo", 32'(wr_en), 32'd0);
      repeat (98) sample(8'd50);
      check("pre99_state", 32'(state), 32'd1);
      check("pre99_wr_addr", 32'(wr_addr), 32'd99);
      sample(8'd50);
      check("pre100_state", 32'(state), 32'd2);
      check("pre100_wr_addr", 32'(wr_addr), 32'd100);
      pulse_arm();
      check("wait_arm_ignored", 32'(state), 32'd2);
      repeat (49) sample(8'd50);
      sample(8'd100);
      check("wait_below_state", 32'(state), 32'd2);
      check("wait_wr_addr", 32'(wr_addr), 32'd150);
      sample(8'd130);
      check("trig_state", 32'(state), 32'd3);
      check("trig_addr_150", 32'(trig_addr), 32'd150);
      pulse_arm();
      check("post_arm_ignored", 32'(state), 32'd3);
      repeat (298) sample(8'd50);
      check("post298_state", 32'(state), 32'd3);
      sample(8'd50);
      check("disp_state", 32'(state), 32'd4);
      check("disp_rd_start", 32'(rd_addr), 32'd50);
      check("disp_frame_ready", 32'(frame_ready), 32'd1);
      check("disp_wr_addr", 32'(wr_addr), 32'd50);
      sample_en = 1'b1;
      rd_en     = 1'b1;
      #1;
      check("disp_wr_en", 32'(wr_en), 32'd0);
      tick();
      sample_en = 1'b0;
      rd_en     = 1'b0;
      check("disp_rd_step", 32'(rd_addr), 32'd51);
      check("disp_wr_hold", 32'(wr_addr), 32'd50);
      repeat (398) read_one();
      check("rep399_state", 32'(state), 32'd4);
      check("rep399_rd_addr", 32'(rd_addr), 32'd49);
      read_one();
      check("rep400_state", 32'(state), 32'd1);
      check("rep400_frame_ready", 32'(frame_ready), 32'd0);
      check("rep400_rd_addr", 32'(rd_addr), 32'd50);
      check("rep400_wr_addr", 32'(wr_addr), 32'd0);

      // ---------- trigger at 20, wrapping read-out, single mode ----------
      do_reset();
      single_mode = 1'b1;
      pulse_arm();
      repeat (420) sample(8'd50);
      check("wrap_wr_addr", 32'(wr_addr), 32'd20);
      check("wrap_wait_state", 32'(state), 32'd2);
      sample(8'd200);
      check("wrap_trig_addr", 32'(trig_addr), 32'd20);
      repeat (299) sample(8'd50);
      check("wrap_disp_state", 32'(state), 32'd4);
      check("wrap_rd_start", 32'(rd_addr), 32'd320);
      single_mode = 1'b0;   // must not affect the current frame
      repeat (79) read_one();
      check("wrap_rd_399", 32'(rd_addr), 32'd399);
      read_one();
      check("wrap_rd_0", 32'(rd_addr), 32'd0);
      repeat (320) read_one();
      check("single400_state", 32'(state), 32'd4);
      check("single400_rd_addr", 32'(rd_addr), 32'd320);
      repeat (400) read_one();
      check("single800_state", 32'(state), 32'd4);
      check("single800_rd_addr", 32'(rd_addr), 32'd320);
      check("single800_frame_ready", 32'(frame_ready), 32'd1);
      pulse_arm();
      check("single_arm_state", 32'(state), 32'd1);
      check("single_arm_frame_ready", 32'(frame_ready), 32'd0);
      check("single_arm_wr_addr", 32'(wr_addr), 32'd0);

      // ---------- reset in the middle of POST ----------
      repeat (100) sample(8'd50);
      sample(8'd200);
      repeat (10) sample(8'd50);
      check("mid_post_state", 32'(state), 32'd3);
      sys_rst   = 1'b1;
      sample_en = 1'b1;
      arm       = 1'b1;
      rd_en     = 1'b1;
      #1;
      check("rst_post_wr_en", 32'(wr_en), 32'd0);
      tick();
      check("rst_post_state", 32'(state), 32'd0);
      check("rst_post_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_post_rd_addr", 32'(rd_addr), 32'd0);
      check("rst_post_trig_addr", 32'(trig_addr), 32'd0);
      check("rst_post_wr_en2", 32'(wr_en), 32'd0);
      check("rst_post_frame_ready", 32'(frame_ready), 32'd0);
      sys_rst   = 1'b0;
      sample_en = 1'b0;
      arm       = 1'b0;
      rd_en     = 1'b0;

      // ---------- flat input below level: auto-trigger or none ----------
      do_reset();
      trig_slope = 1'b1;
      trig_level = 8'd128;
      pulse_arm();
      repeat (100) sample(8'd50);
`ifdef TRIG_AUTO_TIMEOUT_EN
      repeat (3999) sample(8'd50);
      check("to3999_state", 32'(state), 32'd2);
      sample(8'd50);
      check("to4000_state", 32'(state), 32'd3);
      check("to4000_trig_addr", 32'(trig_addr), 32'd99);
`else
      repeat (10000) sample(8'd50);
      check("flat10000_state", 32'(state), 32'd2);
      check("flat10000_trig_addr", 32'(trig_addr), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/trigger_ctrl.md
TRIGGER_CTRL -- requirements
Module: trigger_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 400, giving frame length in samples, one full dual-frame.
REQ-002 The block SHALL have parameter PRE_TRIG, default 100, giving samples kept before the trigger point, legal range 1..DEPTH-2.
REQ-003 The block SHALL have parameter TIMEOUT, default 4000, giving the auto-trigger timeout in accepted samples.
REQ-004 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port sample_en, input, 1 bit: one-cycle strobe meaning adc_data is valid.
REQ-007 The block SHALL have port adc_data, input, 8 bits: channel-a sample used for the trigger.
REQ-008 The block SHALL have port trig_level, input, 8 bits: trigger threshold, unsigned.
REQ-009 The block SHALL have port trig_slope, input, 1 bit: 1 selects rising edge, 0 selects falling edge.
REQ-010 The block SHALL have port single_mode, input, 1 bit: 1 selects single-shot, 0 selects repetitive.
REQ-011 The block SHALL have port arm, input, 1 bit: one-cycle request to start an acquisition.
REQ-012 The block SHALL have port rd_en, input, 1 bit: display read strobe.
REQ-013 The block SHALL have port wr_addr, output, 9 bits: frame RAM write address.
REQ-014 The block SHALL have port wr_en, output, 1 bit: frame RAM write enable.
REQ-015 The block SHALL have port rd_addr, output, 9 bits: frame RAM read address.
REQ-016 The block SHALL have port trig_addr, output, 9 bits: RAM address of the trigger sample.
REQ-017 The block SHALL have port frame_ready, output, 1 bit: high while a complete frame is displayable.
REQ-018 The block SHALL have port state, output, 3 bits: current FSM state code.

Function
REQ-019 The FSM states SHALL be IDLE=0, PRE=1, WAIT=2, POST=3, DISP=4; other codes are unreachable and SHALL decode to IDLE.
REQ-020 IDLE->PRE SHALL occur on arm, clearing wr_addr, the pre-count, the post-count and the timeout count.
REQ-021 In PRE, WAIT and POST, wr_en SHALL equal sample_en combinationally, and wr_addr SHALL advance by 1 per sample, wrapping from DEPTH-1 to 0.
REQ-022 PRE->WAIT SHALL occur after PRE_TRIG samples have been written; no trigger is evaluated in PRE.
REQ-023 A trigger SHALL be detected in WAIT on a sample when it compares with the previous sample as follows: rising means prev<trig_level and cur>=trig_level; falling means prev>trig_level and cur<=trig_level.
REQ-024 On a trigger, trig_addr SHALL latch the wr_addr of that sample, and the FSM SHALL move to POST.
REQ-025 POST SHALL write DEPTH-PRE_TRIG-1 further samples and then move to DISP, with wr_en forced to 0 from that cycle.
REQ-026 On entry to DISP, rd_addr SHALL load (trig_addr+DEPTH-PRE_TRIG) mod DEPTH, and frame_ready SHALL rise the same cycle.
REQ-027 In DISP, each rd_en SHALL advance rd_addr by 1 with wrap at DEPTH-1; after DEPTH reads, rd_addr SHALL return to the start address.
REQ-028 In repetitive mode, completion of DEPTH reads SHALL re-enter PRE (frame_ready falls).
REQ-029 In single mode, the FSM SHALL remain in DISP and re-read indefinitely until arm, which goes to PRE.
REQ-030 arm received in PRE, WAIT or POST SHALL be ignored.
REQ-031 When sample_en and rd_en occur together, both SHALL be honoured; rd_en outside DISP SHALL be ignored.
REQ-032 A change of single_mode SHALL take effect at the next frame boundary only.

Reset
REQ-033 On sys_rst, the FSM SHALL enter IDLE and wr_addr, rd_addr, trig_addr, all counters and the previous-sample register SHALL be 0.
REQ-034 On sys_rst, wr_en and frame_ready SHALL be 0; reset SHALL override arm, sample_en and rd_en in the same cycle, including mid-acquisition.

Configuration
REQ-035 With macro TRIG_AUTO_TIMEOUT_EN defined, WAIT SHALL force a trigger on the sample that makes the timeout count reach TIMEOUT, with identical latching.
REQ-036 Without TRIG_AUTO_TIMEOUT_EN, WAIT SHALL wait indefinitely, and the timeout counter SHALL not exist.

Verification
REQ-037 Scenario: reset, then arm, then 99 samples -> state=PRE; on the 100th sample -> state=WAIT, and wr_addr=100.
REQ-038 Scenario: trig_level=128, rising, samples 100 then 130 in WAIT at wr_addr 150 -> trig_addr=150; after 299 more samples -> DISP with rd_addr=50.
REQ-039 Scenario: trigger at wr_addr 20 -> rd_addr starts at 320 and wraps 399->0, and 400 rd_en return it to 320.
REQ-040 Scenario: single_mode=1, 800 rd_en -> state stays DISP; arm -> PRE, frame_ready=0.
REQ-041 Scenario: sys_rst asserted in POST -> next cycle state=IDLE, with all outputs 0.
REQ-042 Scenario: TRIG_AUTO_TIMEOUT_EN defined, flat input 50, level 128 -> trigger forced on the 4000th WAIT sample; with the macro undefined, no trigger after 10000 samples.
